// File: rtl/pwm_channel_sequencer_pkg.sv
// Shared definitions for the lamp PWM channel sequencer: channel count,
// FSM state encoding and channel-selection helpers.
package pwm_channel_sequencer_pkg;

   localparam int N_CH = 3;

   typedef logic [1:0] ch_idx_t;

   typedef enum logic [1:0] {
      ST_OFF     = 2'd0,
      ST_MANUAL  = 2'd1,
      ST_SEQ_ON  = 2'd2,
      ST_SEQ_GAP = 2'd3
   } seq_state_e;

   // Lowest set bit of the mask; channel 0 when the mask is empty.
   function automatic ch_idx_t lowest_ch(input logic [N_CH-1:0] mask);
      ch_idx_t idx;
      idx = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (mask[i]) idx = ch_idx_t'(i);
      end
      return idx;
   endfunction

   // Next channel after cur, wrapping 2->0, restricted to the mask.
   // Returns cur itself when no other channel is eligible.
   function automatic ch_idx_t next_ch(input ch_idx_t cur, input logic [N_CH-1:0] mask);
      ch_idx_t idx;
      ch_idx_t cand;
      idx = cur;
      for (int k = N_CH - 1; k >= 1; k--) begin
         cand = ch_idx_t'((int'(cur) + k) % N_CH);
         if (mask[cand]) idx = cand;
      end
      return idx;
   endfunction

   function automatic logic [N_CH-1:0] ch_mask(input ch_idx_t idx);
      logic [N_CH-1:0] m;
      m = '0;
      m[idx] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/pwm_channel_sequencer_switch_debouncer.sv
// Two-flop synchronizer followed by a stable-sample counter; the output only
// takes a new level after DEBOUNCE_CYCLES consecutive identical samples.
module pwm_channel_sequencer_switch_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk_50MHz,
   input  logic rst_n,
   input  logic sw_raw,
   output logic sw_deb
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_1;
   logic          sync_2;
   logic [CW-1:0] stable_cnt;

   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         sync_1     <= 1'b0;
         sync_2     <= 1'b0;
         sw_deb     <= 1'b0;
         stable_cnt <= '0;
      end else begin
         sync_1 <= sw_raw;
         sync_2 <= sync_1;
         // Any sample matching the accepted level restarts the count.
         if (sync_2 == sw_deb) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CNT_LAST) begin
            sw_deb     <= sync_2;
            stable_cnt <= '0;
         end else begin
            stable_cnt <= stable_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/pwm_channel_sequencer.sv
// Gates three lamp PWM channels onto the driver pins, either by manual
// enables or as a timed rotation with break-before-make blanking.
module pwm_channel_sequencer
   import pwm_channel_sequencer_pkg::*;
#(
   parameter int DWELL_CYCLES    = 100_000_000,
   parameter int GAP_CYCLES      = 50_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic             clk_50MHz,
   input  logic             rst_n,
   input  logic [N_CH-1:0]  sw_en,
   input  logic             sw_seq,
   input  logic [N_CH-1:0]  pwm_in,
   output logic [N_CH-1:0]  pwm_out,
   output logic [N_CH-1:0]  led,
   output logic             seq_active,
   output seq_state_e       dbg_state
);

   localparam int DW = $clog2(DWELL_CYCLES + 1);
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   logic [N_CH-1:0] en;
   logic            seq;

   for (genvar i = 0; i < N_CH; i++) begin : g_en_deb
      pwm_channel_sequencer_switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk_50MHz (clk_50MHz),
         .rst_n     (rst_n),
         .sw_raw    (sw_en[i]),
         .sw_deb    (en[i])
      );
   end

   pwm_channel_sequencer_switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_seq_deb (
      .clk_50MHz (clk_50MHz),
      .rst_n     (rst_n),
      .sw_raw    (sw_seq),
      .sw_deb    (seq)
   );

   seq_state_e      state, state_n;
   ch_idx_t         ch_idx, ch_n;
   ch_idx_t         nxt_idx, nxt_n;
   logic [DW-1:0]   dwell_cnt, dwell_n;
   logic [GW-1:0]   gap_cnt, gap_n;
   logic [N_CH-1:0] mask_n;
   logic [N_CH-1:0] pwm_sync_1, pwm_sync_2;

   logic [N_CH-1:0] elig;
   ch_idx_t         nxt_calc;
   logic            ch_lost;

   // An empty enable set means "rotate through everything".
   assign elig     = (en != '0) ? en : {N_CH{1'b1}};
   assign nxt_calc = next_ch(ch_idx, elig);
   assign ch_lost  = (en != '0) && !en[ch_idx];

   always_comb begin
      state_n = state;
      ch_n    = ch_idx;
      nxt_n   = nxt_idx;
      dwell_n = dwell_cnt;
      gap_n   = gap_cnt;
      case (state)
         ST_OFF, ST_MANUAL: begin
            if (seq) begin
               state_n = ST_SEQ_ON;
               ch_n    = lowest_ch(en);
               dwell_n = '0;
               gap_n   = '0;
            end else begin
               state_n = (en != '0) ? ST_MANUAL : ST_OFF;
            end
         end
         ST_SEQ_ON: begin
            if (!seq) begin
               state_n = (en != '0) ? ST_MANUAL : ST_OFF;
               ch_n    = '0;
               dwell_n = '0;
               gap_n   = '0;
            end else if (ch_lost || dwell_cnt == DWELL_LAST) begin
               if (nxt_calc == ch_idx) begin
                  dwell_n = '0;
               end else if (GAP_CYCLES == 0) begin
                  ch_n    = nxt_calc;
                  dwell_n = '0;
               end else begin
                  state_n = ST_SEQ_GAP;
                  nxt_n   = nxt_calc;
                  dwell_n = '0;
                  gap_n   = '0;
               end
            end else begin
               dwell_n = dwell_cnt + DW'(1);
            end
         end
         ST_SEQ_GAP: begin
            if (!seq) begin
               state_n = (en != '0) ? ST_MANUAL : ST_OFF;
               ch_n    = '0;
               dwell_n = '0;
               gap_n   = '0;
            end else if (gap_cnt == GAP_LAST) begin
               state_n = ST_SEQ_ON;
               ch_n    = nxt_idx;
               dwell_n = '0;
               gap_n   = '0;
            end else begin
               gap_n = gap_cnt + GW'(1);
            end
         end
         default: state_n = ST_OFF;
      endcase
   end

   // The gating mask follows the next state so outputs stay aligned with it.
   always_comb begin
      mask_n = '0;
      case (state_n)
         ST_MANUAL: mask_n = en;
         ST_SEQ_ON: mask_n = ch_mask(ch_n);
         default:   mask_n = '0;
      endcase
   end

   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_OFF;
         ch_idx     <= '0;
         nxt_idx    <= '0;
         dwell_cnt  <= '0;
         gap_cnt    <= '0;
         pwm_sync_1 <= '0;
         pwm_sync_2 <= '0;
         pwm_out    <= '0;
         led        <= '0;
         seq_active <= 1'b0;
      end else begin
         state      <= state_n;
         ch_idx     <= ch_n;
         nxt_idx    <= nxt_n;
         dwell_cnt  <= dwell_n;
         gap_cnt    <= gap_n;
         pwm_sync_1 <= pwm_in;
         pwm_sync_2 <= pwm_sync_1;
         pwm_out    <= pwm_sync_2 & mask_n;
         led        <= mask_n;
         seq_active <= (state_n == ST_SEQ_ON) || (state_n == ST_SEQ_GAP);
      end
   end

   assign dbg_state = state;

endmodule
